bcd_operand_entry: RTL

Sequential operand-capture stage feeding the two-digit BCD adder. The user sets a BCD digit on switches and presses a pushbutton twice: the first press captures operand A, the second captures operand B and the carry-in. The stage then holds {A, B, cin} stable with a valid/ready handshake for the adder/display stage downstream. Non-BCD digits (0xA–0xF) are rejected with an error flag, so only legal operands reach the adder.

---
 rtl/bcd_operand_entry.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - two-press BCD operand capture with debounce and valid/ready hold (option macro: DEBOUNCE_FILTER_EN)
module bcd_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       cin_in,
    input  logic       enter_n,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic       out_cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] state_led,
    output logic       err
);

    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

    // The counter must be able to reach DEBOUNCE_CYCLES-1
    if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cfg
        $error("bcd_operand_entry: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic sync1_q, sync2_q;
    logic db_q;
    logic db_prev_q;
    logic press;

    // Two-flop synchronizer for the asynchronous pushbutton; idles released (1)
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= enter_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_FILTER_EN
    logic [CNT_W-1:0] cnt_q;

    // Accept a level change only after it has been stable for DEBOUNCE_CYCLES
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b1;
        end else if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_q  <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end
`else
    // No filter: the synchronized level is used directly
    always_comb db_q = sync2_q;
`endif

    // Remember the previous debounced level for falling-edge detection
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) db_prev_q <= 1'b1;
        else       db_prev_q <= db_q;
    end

    // One-cycle pulse when the debounced button goes from released to pressed
    assign press = db_prev_q & ~db_q;

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic       cin_q, cin_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       digit_ok;

    assign digit_ok = (digit_in <= 4'd9);

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= S_A;
        else       state_q <= state_d;
    end

    // Next-state: legal presses advance A->B->HOLD, the handshake returns to A
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:     if (press && digit_ok) state_d = S_B;
            S_B:     if (press && digit_ok) state_d = S_HOLD;
            S_HOLD:  if (out_ready)         state_d = S_A;
            default: state_d = S_A;
        endcase
    end

    // Capture logic; a press in HOLD is ignored, so a coincident press and ready drops the press
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_A: begin
                if (press) begin
                    if (digit_ok) begin
                        a_d   = digit_in;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_B: begin
                if (press) begin
                    if (digit_ok) begin
                        b_d     = digit_in;
                        cin_d   = cin_in;
                        err_d   = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) valid_d = 1'b0;
            end
            default: valid_d = 1'b0;
        endcase
    end

    // Operand registers persist after the transfer so the display keeps showing them
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_cin   = cin_q;
    assign out_valid = valid_q;
    assign err       = err_q;
    assign state_led = state_q;

endmodule
